// File: rtl/collision_pkg.sv
// Shared types, geometry width and helpers for the collision scanner.
package collision_pkg;
  localparam int CW = 10;

  typedef logic [CW-1:0] coord_t;
  typedef logic [CW:0]   wcoord_t;

  typedef struct packed {
    logic   valid;
    coord_t xmin;
    coord_t xmax;
    coord_t top;
    coord_t bot;
  } rect_t;

  // hazard_y all-ones means the level has no floor hazard.
  typedef struct packed {
    coord_t goal_x0;
    coord_t goal_x1;
    coord_t goal_y0;
    coord_t goal_y1;
    coord_t hazard_y;
    coord_t hz_x0;
    coord_t hz_w;
  } level_info_t;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESOLVE} state_e;

  function automatic logic overlap(input wcoord_t a0, input wcoord_t a1,
                                   input wcoord_t b0, input wcoord_t b1);
    return (a0 <= b1) && (b0 <= a1);
  endfunction

  function automatic rect_t mk_rect(input logic v, input int xmin, input int xmax,
                                    input int top, input int bot);
    return '{valid: v, xmin: coord_t'(xmin), xmax: coord_t'(xmax),
             top: coord_t'(top), bot: coord_t'(bot)};
  endfunction

  function automatic level_info_t mk_info(input int gx0, input int gx1, input int gy0,
                                          input int gy1, input int hy, input int hx0,
                                          input int hw);
    return '{goal_x0: coord_t'(gx0), goal_x1: coord_t'(gx1), goal_y0: coord_t'(gy0),
             goal_y1: coord_t'(gy1), hazard_y: coord_t'(hy), hz_x0: coord_t'(hx0),
             hz_w: coord_t'(hw)};
  endfunction
endpackage

// File: rtl/collision_scanner_if.sv
// Request/result bundle between the physics FSM (master) and the collision scanner (slave).
interface collision_scanner_if import collision_pkg::*; #(parameter int LVL_W = 2);
  logic             start;
  coord_t           player_x;
  coord_t           player_y;
  logic [LVL_W-1:0] level;
  coord_t           hazard_height;
  logic             busy;
  logic             done;
  logic             on_ground;
  coord_t           support_y;
  logic             hit_ceiling;
  logic             hit_left_wall;
  logic             hit_right_wall;
  logic             at_goal_region;
  logic             in_hazard;

  modport master (output start, player_x, player_y, level, hazard_height,
                  input  busy, done, on_ground, support_y, hit_ceiling, hit_left_wall,
                         hit_right_wall, at_goal_region, in_hazard);
  modport slave  (input  start, player_x, player_y, level, hazard_height,
                  output busy, done, on_ground, support_y, hit_ceiling, hit_left_wall,
                         hit_right_wall, at_goal_region, in_hazard);
endinterface

// File: rtl/collision_scanner_level_map_rom.sv
// Combinational level map: (level, idx) -> platform rectangle, plus per-level goal/hazard record.
module level_map_rom import collision_pkg::*; #(
  parameter int LVL_W = 2,
  parameter int IDX_W = 4
) (
  input  logic [LVL_W-1:0] level_i,
  input  logic [IDX_W-1:0] idx_i,
  output rect_t            rect_o,
  output level_info_t      info_o
);
  always_comb begin
    rect_o = '0;
    info_o = mk_info(0, 0, 0, 0, 1023, 0, 1);
    case (32'(level_i))
      0: begin
        info_o = mk_info(580, 630, 355, 360, 470, 272, 60);
        case (32'(idx_i))
          0:       rect_o = mk_rect(1'b1,   0,  60, 440, 460);
          1:       rect_o = mk_rect(1'b1,  90, 270, 360, 380);
          2:       rect_o = mk_rect(1'b0,  90, 270, 340, 350);  // disabled ledge
          3:       rect_o = mk_rect(1'b1, 300, 400, 300, 320);
          4:       rect_o = mk_rect(1'b1, 240, 270, 220, 380);
          5:       rect_o = mk_rect(1'b1, 300, 400, 306, 330);
          default: rect_o = '0;
        endcase
      end
      1: begin
        info_o = mk_info(0, 15, 0, 15, 1023, 400, 100);
        if (idx_i == '0) rect_o = mk_rect(1'b1, 0, 639, 400, 420);
      end
      2: begin
        info_o = mk_info(600, 639, 0, 20, 1023, 0, 640);
        if (idx_i == '0) rect_o = mk_rect(1'b1, 0, 100, 16, 30);
      end
      3: begin
        info_o = mk_info(0, 20, 460, 479, 450, 0, 100);
        if (idx_i == '0) rect_o = mk_rect(1'b1, 200, 400, 300, 310);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/collision_scanner.sv
// Sequential collision scanner: walks one map rectangle per clock and registers the results.
// Optional rising hazard band enabled by defining RISING_HAZARD_EN.
module collision_scanner import collision_pkg::*; #(
  parameter int N_PLAT   = 12,
  parameter int N_LEVEL  = 4,
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 16,
  parameter int LAND_TOL = 8,
  parameter int CEIL_TOL = 12,
  parameter int WALL_TOL = 2,
  parameter int SCREEN_H = 480
) (
  input logic                 clk,
  input logic                 rst_n,
  collision_scanner_if.slave  bus
);
  localparam int LVL_W = (N_LEVEL > 1) ? $clog2(N_LEVEL) : 1;
  localparam int IDX_W = (N_PLAT > 1) ? $clog2(N_PLAT) : 1;

  function automatic wcoord_t ext(input coord_t v);
    return {1'b0, v};
  endfunction

  function automatic wcoord_t sat_sub(input coord_t a, input int unsigned b);
    if (32'(a) < b) return '0;
    return ext(a) - wcoord_t'(b);
  endfunction

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  coord_t           px_q, py_q;
  logic [LVL_W-1:0] lvl_q;
  logic             has_sup_q, has_sup_d;
  coord_t           sup_q, sup_d;
  logic             ceil_q, ceil_d, lw_q, lw_d, rw_q, rw_d;
  logic             done_q, on_ground_q, hit_ceiling_q, hit_left_q, hit_right_q;
  logic             goal_q, hazard_q;
  coord_t           support_y_q;

  rect_t       rect_w;
  level_info_t info_w;

  level_map_rom #(.LVL_W(LVL_W), .IDX_W(IDX_W)) u_rom (
    .level_i (lvl_q),
    .idx_i   (idx_q),
    .rect_o  (rect_w),
    .info_o  (info_w)
  );

  wcoord_t x_lo, x_hi, y_lo, y_hi, feet;
  assign x_lo = ext(px_q);
  assign x_hi = x_lo + wcoord_t'(PLAYER_W - 1);
  assign y_lo = ext(py_q);
  assign feet = y_lo + wcoord_t'(PLAYER_H);
  assign y_hi = feet - wcoord_t'(1);

  logic x_ov_w, y_ov_w, land_w;
  assign x_ov_w = overlap(x_lo, x_hi, ext(rect_w.xmin), ext(rect_w.xmax));
  assign y_ov_w = overlap(y_lo, y_hi, ext(rect_w.top), ext(rect_w.bot));
  assign land_w = x_ov_w && (ext(rect_w.top) <= feet) &&
                  (feet <= ext(rect_w.top) + wcoord_t'(LAND_TOL));

  // Strict '>' keeps the earliest entry when two supports share a top.
  always_comb begin
    has_sup_d = has_sup_q;
    sup_d     = sup_q;
    ceil_d    = ceil_q;
    lw_d      = lw_q;
    rw_d      = rw_q;
    if (rect_w.valid) begin
      if (land_w && (!has_sup_q || rect_w.top > sup_q)) begin
        has_sup_d = 1'b1;
        sup_d     = rect_w.top;
      end
      ceil_d = ceil_q | (x_ov_w && (sat_sub(rect_w.bot, CEIL_TOL) <= y_lo) &&
                         (y_lo <= ext(rect_w.bot)));
      lw_d   = lw_q | (y_ov_w && (sat_sub(rect_w.xmax, WALL_TOL) <= x_lo) &&
                       (x_lo <= ext(rect_w.xmax)));
      rw_d   = rw_q | (y_ov_w && (ext(rect_w.xmin) <= x_hi) &&
                       (x_hi <= ext(rect_w.xmin) + wcoord_t'(WALL_TOL)));
    end
  end

  logic goal_w, floor_haz_w, band_haz_w;
  assign goal_w = overlap(x_lo, x_hi, ext(info_w.goal_x0), ext(info_w.goal_x1)) &&
                  overlap(y_lo, y_hi, ext(info_w.goal_y0), ext(info_w.goal_y1));
  assign floor_haz_w = (info_w.hazard_y != '1) && (feet >= ext(info_w.hazard_y)) && !has_sup_q;

`ifdef RISING_HAZARD_EN
  coord_t  hh_q;
  wcoord_t band_top_w;
  assign band_top_w = (ext(hh_q) >= wcoord_t'(SCREEN_H)) ? '0 : wcoord_t'(SCREEN_H) - ext(hh_q);
  assign band_haz_w = (hh_q != '0) &&
                      overlap(x_lo, x_hi, ext(info_w.hz_x0),
                              ext(info_w.hz_x0) + ext(info_w.hz_w) - wcoord_t'(1)) &&
                      overlap(y_lo, y_hi, band_top_w, wcoord_t'(SCREEN_H - 1));
`else
  logic unused_hz;
  assign unused_hz  = ^{info_w.hz_x0, info_w.hz_w, bus.hazard_height};
  assign band_haz_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      px_q          <= '0;
      py_q          <= '0;
      lvl_q         <= '0;
      has_sup_q     <= 1'b0;
      sup_q         <= '0;
      ceil_q        <= 1'b0;
      lw_q          <= 1'b0;
      rw_q          <= 1'b0;
      done_q        <= 1'b0;
      on_ground_q   <= 1'b0;
      support_y_q   <= '0;
      hit_ceiling_q <= 1'b0;
      hit_left_q    <= 1'b0;
      hit_right_q   <= 1'b0;
      goal_q        <= 1'b0;
      hazard_q      <= 1'b0;
`ifdef RISING_HAZARD_EN
      hh_q          <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          state_q   <= S_SCAN;
          idx_q     <= '0;
          px_q      <= bus.player_x;
          py_q      <= bus.player_y;
          lvl_q     <= bus.level;
          has_sup_q <= 1'b0;
          sup_q     <= '0;
          ceil_q    <= 1'b0;
          lw_q      <= 1'b0;
          rw_q      <= 1'b0;
`ifdef RISING_HAZARD_EN
          hh_q      <= bus.hazard_height;
`endif
        end
        S_SCAN: begin
          has_sup_q <= has_sup_d;
          sup_q     <= sup_d;
          ceil_q    <= ceil_d;
          lw_q      <= lw_d;
          rw_q      <= rw_d;
          if (idx_q == IDX_W'(N_PLAT - 1)) state_q <= S_RESOLVE;
          else                             idx_q   <= idx_q + 1'b1;
        end
        S_RESOLVE: begin
          on_ground_q   <= has_sup_q;
          support_y_q   <= sup_q;
          hit_ceiling_q <= ceil_q;
          hit_left_q    <= lw_q;
          hit_right_q   <= rw_q;
          goal_q        <= goal_w;
          hazard_q      <= floor_haz_w || band_haz_w;
          done_q        <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy           = (state_q != S_IDLE);
  assign bus.done           = done_q;
  assign bus.on_ground      = on_ground_q;
  assign bus.support_y      = support_y_q;
  assign bus.hit_ceiling    = hit_ceiling_q;
  assign bus.hit_left_wall  = hit_left_q;
  assign bus.hit_right_wall = hit_right_q;
  assign bus.at_goal_region = goal_q;
  assign bus.in_hazard      = hazard_q;
endmodule
